// File: rtl/popcnt_pkg.sv
// Shared definitions for the popcount word generator.
//  - state_e      : FSM state encoding (IDLE / FILL / OUT)
//  - LFSR_TAPS16  : Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shift form)
//  - DEFAULT_SEED : LFSR value after reset
//  - cnt_width()  : width of a ones-count for a w-bit word, $clog2(w)+1
package popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS16  = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/popcnt_gen_probe.sv
// Combinational first-clear-bit finder with wrap-around.
// Starting at bit position cand, scans upward through word and wraps from
// WIDTH-1 back to 0; index is the first position holding a 0.
// Ports:
//  word  in   WIDTH   partially filled word
//  cand  in   IDX_W   starting position
//  index out  IDX_W   first clear position at or above cand (with wrap)
// If word is all ones, index falls back to cand; the caller never probes a
// full word because at most WIDTH-1 bits are set when a bit is placed.
module popcnt_gen_probe #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [IDX_W-1:0] cand,
  output logic [IDX_W-1:0] index
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    index = cand;
    found = 1'b0;
    pos   = cand;
    for (int i = 0; i < WIDTH; i++) begin
      // WIDTH is a power of two, so the IDX_W-bit add wraps naturally.
      pos = cand + IDX_W'(i);
      if (!found && !word[pos]) begin
        index = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/popcount_word_gen.sv
// Popcount word generator: accepts a requested ones-count and emits a
// WIDTH-bit word with exactly that many set bits at LFSR-chosen positions.
// Optional feature macro: POPCOUNT_GEN_CHECK_EN (internal popcount checker
// driving a sticky err_o; when undefined err_o is tied low).
// Ports:
//  clk_i        in   1       clock, all logic on posedge
//  rst_ni       in   1       synchronous active-low reset
//  seed_i       in   LFSR_W  new LFSR seed (zero ignored)
//  seed_load_i  in   1       load seed_i, honoured in IDLE only
//  req_cnt_i    in   CNT_W   requested number of set bits (clamped to WIDTH)
//  req_valid_i  in   1       request valid
//  req_ready_o  out  1       request ready
//  data_o       out  WIDTH   generated word
//  cnt_o        out  CNT_W   ones-count placed
//  valid_o      out  1       data_o/cnt_o valid
//  ready_i      in   1       consumer ready
//  err_o        out  1       sticky self-check mismatch
//  state_o      out  state_e FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The requester holds req_valid_i/req_cnt_i until req_ready_o is
// seen high at an edge; the generator holds valid_o/data_o/cnt_o stable until
// ready_i is seen high at an edge. Neither valid depends combinationally on
// its ready.
module popcount_word_gen
  import popcnt_pkg::*;
#(
  parameter int                WIDTH  = 16,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [LFSR_W-1:0]            seed_i,
  input  logic                         seed_load_i,
  input  logic [$clog2(WIDTH):0]       req_cnt_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(WIDTH):0]       cnt_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         err_o,
  output state_e                       state_o
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS16);
  localparam logic [CNT_W-1:0]  FULL = CNT_W'(WIDTH);

  state_e            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_step;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  k_clamped;
  logic [IDX_W-1:0]  probe_idx;
  logic              accept;

  assign accept    = req_valid_i && req_ready_o;
  assign k_clamped = (req_cnt_i > FULL) ? FULL : req_cnt_i;
  assign lfsr_step = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
  assign state_o   = state;

  popcnt_gen_probe #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_probe (
    .word (data_o),
    .cand (lfsr[IDX_W-1:0]),
    .index(probe_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      lfsr        <= SEED;
      remaining   <= '0;
      data_o      <= '0;
      cnt_o       <= '0;
      valid_o     <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // Seed load and accept on the same edge: the new seed is in the
          // LFSR by the first FILL cycle, so it governs this request.
          if (seed_load_i && (seed_i != '0)) begin
            lfsr <= seed_i;
          end
          if (accept) begin
            cnt_o       <= k_clamped;
            data_o      <= '0;
            req_ready_o <= 1'b0;
            if (k_clamped == '0) begin
              state <= OUT;
            end else begin
              remaining <= k_clamped;
              state     <= FILL;
            end
          end
        end
        FILL: begin
          data_o[probe_idx] <= 1'b1;
          lfsr              <= lfsr_step;
          remaining         <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state <= OUT;
          end
        end
        OUT: begin
          // valid_o rises one cycle after entering OUT; the transfer then
          // completes on the first edge with ready_i high.
          if (!valid_o) begin
            valid_o <= 1'b1;
          end else if (ready_i) begin
            valid_o     <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef POPCOUNT_GEN_CHECK_EN
  logic             err_q;
  logic [CNT_W-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CNT_W'(data_o[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((state == OUT) && (ones != cnt_o)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_word_gen.sv
module tb_popcount_word_gen;

  localparam int W  = 16;
  localparam int CW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [15:0]   seed;
  logic          seed_load;
  logic [CW-1:0] req_cnt;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  data;
  logic [CW-1:0] cnt;
  logic          valid;
  logic          ready;
  logic          err;
  popcnt_pkg::state_e state;

  popcount_word_gen dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .seed_i     (seed),
    .seed_load_i(seed_load),
    .req_cnt_i  (req_cnt),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .data_o     (data),
    .cnt_o      (cnt),
    .valid_o    (valid),
    .ready_i    (ready),
    .err_o      (err),
    .state_o    (state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  logic [W-1:0]  obs_log[$];
  logic [W-1:0]  run1_q[$];

  logic [15:0]   m_lfsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Galois form.
  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic [15:0] mask;
    mask = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  task automatic model_gen(input int k, output logic [W-1:0] w, output logic [CW-1:0] c);
    int kk;
    int p;
    kk = (k > W) ? W : k;
    w  = '0;
    for (int n = 0; n < kk; n++) begin
      p = int'(m_lfsr[3:0]);
      while (w[p]) p = (p + 1) % W;
      w[p]   = 1'b1;
      m_lfsr = m_step(m_lfsr);
    end
    c = CW'(kk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input int k, input bit ld, input logic [15:0] sd);
    bit            acc;
    logic [W-1:0]  w;
    logic [CW-1:0] c;
    seed      = sd;
    seed_load = ld;
    req_cnt   = CW'(k);
    req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = req_ready;
      @(posedge clk); #1;
    end
    check("req_accept", acc, 1);
    req_valid = 1'b0;
    seed_load = 1'b0;
    if (ld && sd != 16'h0) m_lfsr = sd;
    model_gen(k, w, c);
    exp_q.push_back(w);
    exp_cnt_q.push_back(c);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done(input bit rnd);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 200) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs    = valid && ready;
      @(posedge clk); #1;
      n++;
    end
    check("out_done", hs, 1);
    ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_data"}, data, 0);
    check({tag, "_cnt"}, cnt, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, state, popcnt_pkg::IDLE);
  endtask

  // ---------------- output monitor ----------------
  logic [W-1:0]  prev_data;
  logic [CW-1:0] prev_cnt;
  bit            have_prev = 1'b0;
  bit            prev_hs   = 1'b0;

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (have_prev && !prev_hs) begin
        check("hold_data", data, prev_data);
        check("hold_cnt", cnt, prev_cnt);
      end
      if (ready) begin
        check("unexpected_out", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("word", data, exp_q.pop_front());
          check("cnt", cnt, exp_cnt_q.pop_front());
        end
        check("popcount", $countones(data), cnt);
        check("err", err, 0);
        obs_log.push_back(data);
      end
      prev_data = data;
      prev_cnt  = cnt;
      prev_hs   = ready;
      have_prev = 1'b1;
    end else begin
      have_prev = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  int lat;
  int seq[6] = '{3, 9, 1, 16, 12, 6};

  initial begin
    rst_n     = 1'b0;
    seed      = '0;
    seed_load = 1'b0;
    req_cnt   = '0;
    req_valid = 1'b0;
    ready     = 1'b1;
    m_lfsr    = 16'hACE1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset");

    // k = 0: empty word one edge after accept
    do_req(0, 1'b0, 16'h0);
    wait_valid(lat);
    check("lat_k0", lat, 1);
    check("k0_data", data, 16'h0000);
    check("k0_cnt", cnt, 0);
    wait_done(1'b0);

    // k = 16: full word
    do_req(16, 1'b0, 16'h0);
    wait_valid(lat);
    check("lat_k16", lat, 17);
    check("k16_data", data, 16'hFFFF);
    wait_done(1'b0);

    // k = 20 clamps to 16
    do_req(20, 1'b0, 16'h0);
    wait_valid(lat);
    check("lat_k20", lat, 17);
    check("k20_data", data, 16'hFFFF);
    check("k20_cnt", cnt, 16);
    wait_done(1'b0);

    // k = 5 with consumer stalled for 10 cycles; a second request is
    // presented during the stall and must not be taken
    ready = 1'b0;
    do_req(5, 1'b0, 16'h0);
    wait_valid(lat);
    check("lat_k5", lat, 6);
    req_valid = 1'b1;
    req_cnt   = CW'(3);
    for (int i = 0; i < 10; i++) begin
      check("stall_req_ready", req_ready, 0);
      check("stall_valid", valid, 1);
      check("stall_pop", $countones(data), 5);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("stall_state", state, popcnt_pkg::OUT);
    wait_done(1'b0);
    @(posedge clk); #1;
    check("idle_after", req_ready, 1);

    // seed load together with accept; then a zero seed that is ignored
    do_req(7, 1'b1, 16'h1234);
    wait_done(1'b0);
    do_req(4, 1'b1, 16'h0000);
    wait_done(1'b0);

    // run A of a fixed sequence from reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    obs_log.delete();
    foreach (seq[i]) begin
      do_req(seq[i], 1'b0, 16'h0);
      wait_done(1'b1);
    end
    run1_q = obs_log;
    obs_log.delete();

    // reset in the middle of FILL drops the partial word
    do_req(10, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("midfill_state", state, popcnt_pkg::FILL);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midfill_reset");
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt_q.delete();
    m_lfsr = 16'hACE1;

    // run B must reproduce run A bit for bit
    foreach (seq[i]) begin
      do_req(seq[i], 1'b0, 16'h0);
      wait_done(1'b1);
    end
    check("replay_len", obs_log.size(), run1_q.size());
    for (int i = 0; i < obs_log.size() && i < run1_q.size(); i++) begin
      check("replay_word", obs_log[i], run1_q[i]);
    end

    // random sweep with random consumer back-pressure
    for (int i = 0; i < 200; i++) begin
      do_req($urandom_range(0, 20), 1'b0, 16'h0);
      wait_done(1'b1);
    end

    @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 0);
    check("final_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
